// File: rtl/apb_master_ctrl.sv
// APB master bridge: turns a valid/ready request into APB SETUP/ACCESS transfers
// and returns a one-cycle response carrying read data, slave error and timeout status.
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_tmo,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr,
  output logic [1:0]          state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic                r_rsp_tmo;

  logic                w_done;
  logic                w_timeout;
  logic                w_ready;
  logic                w_accept;

  // req_ready must see pready in the completion cycle so a follow-on request can
  // be taken without an IDLE gap; it is the only output decoded from live inputs.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_done    = (r_state == ST_ACCESS) && pready;
    w_timeout = TMO_EN && (r_state == ST_ACCESS) && !pready && (r_wait_cnt == TMO_LAST);
    w_ready   = (r_state == ST_IDLE) || w_done;
    w_accept  = req_valid && w_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, e.g. the response uses the finishing transfer's pwrite while
  // the next request is loaded on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: only control and visible datapath registers need reset; the bridge has no memories.
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;

      if (w_accept) begin
        r_paddr  <= req_addr;
        r_pwrite <= req_write;
        r_pwdata <= req_wdata;
        r_pstrb  <= req_write ? req_strb : '0;
      end

      case (r_state)
        ST_IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          if (w_accept) begin
            r_state <= ST_SETUP;
            r_psel  <= 1'b1;
          end
        end

        ST_SETUP: begin
          r_state    <= ST_ACCESS;
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
        end

        ST_ACCESS: begin
          if (pready) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= pslverr;
            r_rsp_tmo   <= 1'b0;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_penable   <= 1'b0;
            if (w_accept) begin
              r_state <= ST_SETUP;   // back-to-back: psel stays high
            end else begin
              r_state <= ST_IDLE;
              r_psel  <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state     <= ST_IDLE;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_tmo   <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign rsp_tmo   = r_rsp_tmo;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign state     = r_state;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: scenario tasks drive requests and an APB
// slave response; a negedge monitor pops expected responses from a scoreboard queue.
module tb_apb_master_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_write;
  logic       req_ready;
  logic [7:0] req_addr, req_wdata;
  logic [0:0] req_strb;
  logic       rsp_valid, rsp_err, rsp_tmo;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [0:0] pstrb;
  logic [7:0] prdata;
  logic       pready, pslverr;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
    logic       tmo;
  } rsp_t;

  rsp_t sb_q[$];
  rsp_t mon_got, mon_exp;

  always #5 clk = ~clk;

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .state(state)
  );

  // {state, psel, penable, pwrite, paddr, pstrb}
  function automatic logic [13:0] apb_vec();
    return {state, psel, penable, pwrite, paddr, pstrb};
  endfunction

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      mon_got = {rsp_rdata, rsp_err, rsp_tmo};
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b tmo=%b, required no response",
                 rsp_rdata, rsp_err, rsp_tmo);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL rsp_data: got rdata=%h err=%b tmo=%b, required rdata=%h err=%b tmo=%b",
                   mon_got.rdata, mon_got.err, mon_got.tmo, mon_exp.rdata, mon_exp.err, mon_exp.tmo);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Full transfer from IDLE with a given number of wait states; called just after a negedge.
  task automatic run_xfer(input string name, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic strb, input int waits,
                          input logic [7:0] rd, input logic err);
    logic exp_strb;
    exp_strb  = wr ? strb : 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
    pready = 1'b0; pslverr = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL %s ready: got %b required 1", name, req_ready);
    end
    sb_q.push_back(rsp_t'({wr ? 8'h00 : rd, err, 1'b0}));

    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_addr = 8'($urandom); req_wdata = 8'($urandom);
    req_strb = ~strb;
    n_cmp++;
    if (apb_vec() !== {2'b01, 1'b1, 1'b0, wr, addr, exp_strb} || pwdata !== wdata) begin
      n_bad++; $display("FAIL %s setup: got %h/%h required %h/%h", name, apb_vec(), pwdata,
                        {2'b01, 1'b1, 1'b0, wr, addr, exp_strb}, wdata);
    end
    pready = 1'b1; pslverr = 1'b1;   // must be ignored during SETUP

    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      n_cmp++;
      if (apb_vec() !== {2'b10, 1'b1, 1'b1, wr, addr, exp_strb} || pwdata !== wdata) begin
        n_bad++; $display("FAIL %s access[%0d]: got %h/%h required %h/%h", name, i, apb_vec(),
                          pwdata, {2'b10, 1'b1, 1'b1, wr, addr, exp_strb}, wdata);
      end
      pready  = (i == waits);
      pslverr = (i == waits) ? err : 1'($urandom);
      prdata  = (i == waits) ? rd : 8'($urandom);
    end

    @(negedge clk);
    pready = 1'b0; pslverr = 1'b0;
    n_cmp++;
    if ({rsp_valid, state, psel, penable} !== 5'b1_00_0_0) begin
      n_bad++; $display("FAIL %s complete: got v/st/sel/en=%b required 10000", name,
                        {rsp_valid, state, psel, penable});
    end

    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_err} !== {1'b0, err}) begin
      n_bad++; $display("FAIL %s pulse_hold: got valid/err=%b required %b", name,
                        {rsp_valid, rsp_err}, {1'b0, err});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_strb = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({state, psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err,
         rsp_tmo, req_ready} !== {2'b00, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1}) begin
      n_bad++; $display("FAIL reset_state: got %h required %h",
        {state, psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_tmo, req_ready},
        {2'b00, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    run_xfer("write", 1'b1, 8'h12, 8'hA5, 1'b1, 0, 8'h6B, 1'b0);
  endtask

  task automatic test_read_wait();
    run_xfer("read_wait", 1'b0, 8'h40, 8'h9D, 1'b1, 3, 8'h3C, 1'b0);
  endtask

  task automatic test_slverr();
    run_xfer("slverr", 1'b1, 8'h33, 8'h5A, 1'b1, 1, 8'h81, 1'b1);
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h11; req_strb = 1'b1;
    pready = 1'b0; pslverr = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b ready1: got %b required 1", req_ready);
    end
    sb_q.push_back(rsp_t'({8'h00, 1'b0, 1'b0}));

    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (apb_vec() !== {2'b01, 3'b101, 8'h20, 1'b1}) begin
      n_bad++; $display("FAIL b2b setup1: got %h required %h", apb_vec(), {2'b01, 3'b101, 8'h20, 1'b1});
    end

    @(negedge clk);
    n_cmp++;
    if (apb_vec() !== {2'b10, 3'b111, 8'h20, 1'b1}) begin
      n_bad++; $display("FAIL b2b access1: got %h required %h", apb_vec(), {2'b10, 3'b111, 8'h20, 1'b1});
    end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h21; req_strb = 1'b1;
    pready = 1'b1; prdata = 8'h99;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b ready2: got %b required 1", req_ready);
    end
    sb_q.push_back(rsp_t'({8'h77, 1'b0, 1'b0}));

    @(negedge clk);
    req_valid = 1'b0; pready = 1'b0;
    n_cmp++;
    if ({rsp_valid, apb_vec()} !== {1'b1, 2'b01, 3'b100, 8'h21, 1'b0}) begin
      n_bad++; $display("FAIL b2b setup2: got %h required %h", {rsp_valid, apb_vec()},
                        {1'b1, 2'b01, 3'b100, 8'h21, 1'b0});
    end

    @(negedge clk);
    n_cmp++;
    if (apb_vec() !== {2'b10, 3'b110, 8'h21, 1'b0}) begin
      n_bad++; $display("FAIL b2b access2: got %h required %h", apb_vec(), {2'b10, 3'b110, 8'h21, 1'b0});
    end
    pready = 1'b1; prdata = 8'h77;

    @(negedge clk);
    pready = 1'b0;
    n_cmp++;
    if ({rsp_valid, state, psel} !== 4'b1_00_0) begin
      n_bad++; $display("FAIL b2b complete2: got %b required 1000", {rsp_valid, state, psel});
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h55; req_strb = 1'b1;
    pready = 1'b0; pslverr = 1'b0; prdata = 8'hC3;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL tmo ready: got %b required 1", req_ready);
    end
    sb_q.push_back(rsp_t'({8'h00, 1'b1, 1'b1}));

    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (apb_vec() !== {2'b01, 3'b100, 8'h55, 1'b0}) begin
      n_bad++; $display("FAIL tmo setup: got %h required %h", apb_vec(), {2'b01, 3'b100, 8'h55, 1'b0});
    end

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (apb_vec() !== {2'b10, 3'b110, 8'h55, 1'b0}) begin
        n_bad++; $display("FAIL tmo access[%0d]: got %h required %h", i, apb_vec(),
                          {2'b10, 3'b110, 8'h55, 1'b0});
      end
    end

    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, state, psel, penable} !== 5'b1_00_0_0) begin
      n_bad++; $display("FAIL tmo abort: got v/st/sel/en=%b required 10000",
                        {rsp_valid, state, psel, penable});
    end

    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_tmo, rsp_err} !== 3'b011) begin
      n_bad++; $display("FAIL tmo hold: got valid/tmo/err=%b required 011", {rsp_valid, rsp_tmo, rsp_err});
    end
  endtask

  task automatic test_reset_access();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h66; req_wdata = 8'hEE; req_strb = 1'b1;
    pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (apb_vec() !== {2'b01, 3'b101, 8'h66, 1'b1}) begin
      n_bad++; $display("FAIL rst_acc setup: got %h required %h", apb_vec(), {2'b01, 3'b101, 8'h66, 1'b1});
    end
    @(negedge clk);
    n_cmp++;
    if (state !== 2'b10) begin
      n_bad++; $display("FAIL rst_acc access: got state %b required 10", state);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({state, psel, penable, rsp_valid, req_ready, paddr} !== {2'b00, 4'b0001, 8'h00}) begin
      n_bad++; $display("FAIL rst_acc idle: got %h required %h",
                        {state, psel, penable, rsp_valid, req_ready, paddr}, {2'b00, 4'b0001, 8'h00});
    end
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, state} !== 3'b0_00) begin
      n_bad++; $display("FAIL rst_acc no_rsp: got valid/state=%b required 000", {rsp_valid, state});
    end
    run_xfer("after_reset", 1'b0, 8'h67, 8'h00, 1'b0, 1, 8'h5E, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_access();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
